aes_key_expand: RTL

Iterative AES-128 key-schedule generator that sits directly upstream of the round-key register bank (B0..B10) in the AES core. It accepts a 128-bit cipher key and emits round keys 0..10, one per handshake, each tagged with its round index, so the controller can write them into the bank. It produces one round key per cycle when the consumer is always ready.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_key_expand.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-schedule generator.
package aes_pkg;

    localparam int KEY_W     = 128;
    localparam int NB_ROUNDS = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } keyexp_state_t;

    typedef enum logic {
        DIR_FWD,
        DIR_REV
    } keyexp_dir_t;

    // Round constant for round r (1..10); other indices are never consumed.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Row-major table: entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule emitting round keys 0..10 over a valid/ready handshake.
// Reverse expansion (round 10 down to 0) is built only when KEY_EXPAND_REVERSE_EN is defined.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NB_ROUNDS = 10,
    parameter int KEY_W     = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             start_rev,
    input  logic [KEY_W-1:0] key_in,
    output logic             idle,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             done
);

    generate
        if (NB_ROUNDS != 10 || KEY_W != 128) begin : g_bad_cfg
            $error("aes_key_expand supports only NB_ROUNDS=10 and KEY_W=128");
        end
    endgenerate

    localparam logic [3:0] LAST_IDX = 4'(NB_ROUNDS);

    keyexp_state_t    state_q, state_d;
    logic [KEY_W-1:0] rk_q, rk_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_in, rot_word, sub_word;
    logic [31:0] fwd_t, n0, n1, n2, n3;
    logic [KEY_W-1:0] fwd_key;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

`ifdef KEY_EXPAND_REVERSE_EN
    keyexp_dir_t      dir_q, dir_d;
    logic [31:0]      p0, p1, p2, p3;
    logic [KEY_W-1:0] rev_key;

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // Both directions share the four S-boxes; only the word fed in differs.
    assign sub_in = (dir_q == DIR_REV) ? p3 : w3;
`else
    logic unused_start_rev;

    assign unused_start_rev = start_rev;
    assign sub_in           = w3;
`endif

    assign rot_word = {sub_in[23:0], sub_in[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*b +: 8]),
            .out_byte (sub_word[8*b +: 8])
        );
    end

    assign fwd_t   = sub_word ^ {rcon(idx_q + 4'd1), 24'h0};
    assign n0      = w0 ^ fwd_t;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign fwd_key = {n0, n1, n2, n3};

`ifdef KEY_EXPAND_REVERSE_EN
    assign p0      = w0 ^ sub_word ^ {rcon(idx_q), 24'h0};
    assign rev_key = {p0, p1, p2, p3};
`endif

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef KEY_EXPAND_REVERSE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    rk_d    = key_in;
                    idx_d   = '0;
`ifdef KEY_EXPAND_REVERSE_EN
                    dir_d   = DIR_FWD;
                end else if (start_rev) begin
                    state_d = ST_RUN;
                    rk_d    = key_in;
                    idx_d   = LAST_IDX;
                    dir_d   = DIR_REV;
`endif
                end
            end
            ST_RUN: begin
                if (rk_ready) begin
`ifdef KEY_EXPAND_REVERSE_EN
                    if (dir_q == DIR_REV) begin
                        if (idx_q == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rk_d  = rev_key;
                            idx_d = idx_q - 4'd1;
                        end
                    end else
`endif
                    begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rk_d  = fwd_key;
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef KEY_EXPAND_REVERSE_EN
            dir_q   <= DIR_FWD;
`endif
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef KEY_EXPAND_REVERSE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign idle     = (state_q == ST_IDLE);
    assign rk_valid = (state_q == ST_RUN);
    assign rk_out   = rk_q;
    assign rk_idx   = idx_q;
    assign done     = done_q;

endmodule
